// File: rtl/sram_axi_bridge_if.sv
// Port bundles for sram_axi_bridge: the core's sram-like request port and the
// single system AXI port, including the constant AXI fields the bridge ties off.
interface sram_if;
    logic        req;
    logic        wr;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (output req, wr, wstrb, addr, wdata, input addr_ok, data_ok, rdata);
    modport slave  (input req, wr, wstrb, addr, wdata, output addr_ok, data_ok, rdata);
endinterface

interface axi_if;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic        rvalid;
    logic        rready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic        bvalid;
    logic        bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output wdata, wstrb, wvalid, bready,
        input  arready, rdata, rvalid, awready, wready, bvalid
    );
    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  wdata, wstrb, wvalid, bready,
        output arready, rdata, rvalid, awready, wready, bvalid
    );
endinterface

// File: rtl/sram_axi_bridge.sv
// Bridges the core's instruction and data sram-like ports onto one AXI port.
// One transaction in flight at a time; the data port wins arbitration.
module sram_axi_bridge (
    input  logic  clk,
    input  logic  reset,
    sram_if.slave inst_sram,
    sram_if.slave data_sram,
    axi_if.master axi
);
    typedef enum logic [2:0] {IDLE, AR, R, AW_W, B, DONE} state_t;

    state_t      state, state_next;
    logic        sel_data;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic        aw_done, w_done;
    logic [31:0] inst_rdata_q, data_rdata_q;

    logic        accept, grant_wr, aw_hs, w_hs, aw_fin, w_fin;
    logic [31:0] grant_addr, grant_wdata;
    logic [3:0]  grant_wstrb;

    always_comb begin
        accept      = (state == IDLE) && (data_sram.req || inst_sram.req);
        grant_wr    = data_sram.req ? data_sram.wr    : inst_sram.wr;
        grant_addr  = data_sram.req ? data_sram.addr  : inst_sram.addr;
        grant_wdata = data_sram.req ? data_sram.wdata : inst_sram.wdata;
        grant_wstrb = data_sram.req ? data_sram.wstrb : inst_sram.wstrb;
        // Handshakes are qualified by the flags, matching the Moore valids below.
        aw_hs       = (state == AW_W) && !aw_done && axi.awready;
        w_hs        = (state == AW_W) && !w_done  && axi.wready;
        aw_fin      = aw_done || aw_hs;
        w_fin       = w_done  || w_hs;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = grant_wr ? AW_W : AR;
            AR:      if (axi.arready) state_next = R;
            R:       if (axi.rvalid) state_next = DONE;
            AW_W:    if (aw_fin && w_fin) state_next = B;
            B:       if (axi.bvalid) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            aw_done      <= 1'b0;
            w_done       <= 1'b0;
            inst_rdata_q <= 32'h0;
            data_rdata_q <= 32'h0;
        end else begin
            state <= state_next;
            if (state == AW_W) begin
                aw_done <= aw_fin && !w_fin;
                w_done  <= w_fin && !aw_fin;
            end
            if (state == R && axi.rvalid) begin
                if (sel_data) data_rdata_q <= axi.rdata;
                else          inst_rdata_q <= axi.rdata;
            end
        end
    end

    // Request fields are captured at accept so the core may change them afterwards.
    always_ff @(posedge clk) begin
        if (accept) begin
            sel_data <= data_sram.req;
            addr_q   <= grant_addr;
            wdata_q  <= grant_wdata;
            wstrb_q  <= grant_wstrb;
        end
    end

    always_comb begin
        data_sram.addr_ok = !reset && (state == IDLE) && data_sram.req;
        inst_sram.addr_ok = !reset && (state == IDLE) && inst_sram.req && !data_sram.req;
        data_sram.data_ok = !reset && (state == DONE) && sel_data;
        inst_sram.data_ok = !reset && (state == DONE) && !sel_data;
        data_sram.rdata   = data_rdata_q;
        inst_sram.rdata   = inst_rdata_q;
        axi.arvalid       = !reset && (state == AR);
        axi.rready        = !reset && (state == R);
        axi.awvalid       = !reset && (state == AW_W) && !aw_done;
        axi.wvalid        = !reset && (state == AW_W) && !w_done;
        axi.bready        = !reset && (state == B);
        axi.araddr        = addr_q;
        axi.awaddr        = addr_q;
        axi.wdata         = wdata_q;
        axi.wstrb         = wstrb_q;
    end

    assign axi.arid    = 4'd0;
    assign axi.arlen   = 8'd0;
    assign axi.arsize  = 3'd2;
    assign axi.arburst = 2'b01;
    assign axi.arlock  = 1'b0;
    assign axi.arcache = 4'd0;
    assign axi.arprot  = 3'd0;
    assign axi.awid    = 4'd0;
    assign axi.awlen   = 8'd0;
    assign axi.awsize  = 3'd2;
    assign axi.awburst = 2'b01;
    assign axi.awlock  = 1'b0;
    assign axi.awcache = 4'd0;
    assign axi.awprot  = 3'd0;
endmodule

// File: tb/tb_sram_axi_bridge.sv
// Bench for sram_axi_bridge: an AXI slave with programmable wait states and a
// word-array reference memory that predicts read data, latencies and AXI fields.
module tb_sram_axi_bridge;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sram_if inst_sram ();
    sram_if data_sram ();
    axi_if  axi ();

    sram_axi_bridge dut (
        .clk       (clk),
        .reset     (reset),
        .inst_sram (inst_sram),
        .data_sram (data_sram),
        .axi       (axi)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] ref_mem   [16];
    logic [31:0] slave_mem [16];
    logic [31:0] last_rd   [2];
    int          ar_dly, r_dly, aw_dly, w_dly, b_dly;
    int          ar_cyc, aw_cyc, w_cyc, araddr_bad;
    logic [31:0] exp_addr, exp_wdata;
    logic [3:0]  exp_wstrb;
    bit          other_seen, aok_seen;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, want);
    endtask

    function automatic logic [31:0] init_word(input int i);
        if (i == 0) return 32'h0280_0404;
        return (32'(i) * 32'h0101_0101) ^ 32'h5A00_00C3;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++)
            if (strb[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    function automatic logic aok(input bit d);
        return d ? data_sram.addr_ok : inst_sram.addr_ok;
    endfunction

    function automatic logic dok(input bit d);
        return d ? data_sram.data_ok : inst_sram.data_ok;
    endfunction

    function automatic logic [31:0] prd(input bit d);
        return d ? data_sram.rdata : inst_sram.rdata;
    endfunction

    task automatic drive(input bit d, input logic req, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] strb);
        if (d) begin
            data_sram.req = req; data_sram.wr = wr; data_sram.addr = addr;
            data_sram.wdata = wdata; data_sram.wstrb = strb;
        end else begin
            inst_sram.req = req; inst_sram.wr = wr; inst_sram.addr = addr;
            inst_sram.wdata = wdata; inst_sram.wstrb = strb;
        end
    endtask

    // Steps cycles until port d signals data_ok; n is the cycle count after accept, -1 on timeout.
    task automatic wait_ok(input bit d, input bit drop, input int limit, output int n);
        n = 0; other_seen = 0; aok_seen = 0;
        do begin
            @(negedge clk);
            if (n == 0 && drop) drive(d, 1'b0, 1'($urandom), $urandom, $urandom, 4'($urandom));
            #1;
            n++;
            if (dok(!d)) other_seen = 1;
            if (inst_sram.addr_ok || data_sram.addr_ok) aok_seen = 1;
        end while (!dok(d) && n < limit);
        if (!dok(d)) n = -1;
    endtask

    task automatic do_txn(input bit d, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] strb);
        int n, k, want_n;
        logic [3:0] idx;
        idx = addr[5:2];
        exp_addr = addr; exp_wdata = wdata; exp_wstrb = strb;
        ar_cyc = 0; aw_cyc = 0; w_cyc = 0; araddr_bad = 0;
        @(negedge clk);
        drive(d, 1'b1, wr, addr, wdata, strb);
        #1;
        k = 0;
        while (!aok(d) && k < 10) begin @(negedge clk); #1; k++; end
        if (!aok(d)) begin
            chk("accept_timeout", 32'h0, 32'h1);
            drive(d, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
            return;
        end
        chk("addr_ok_other", 32'(aok(!d)), 32'h0);
        wait_ok(d, 1'b1, 40, n);
        if (n < 0) begin chk("data_ok_timeout", 32'h0, 32'h1); return; end
        want_n = wr ? 3 + (aw_dly > w_dly ? aw_dly : w_dly) + b_dly : 3 + ar_dly + r_dly;
        chk("latency", n, want_n);
        chk("other_data_ok", 32'(other_seen), 32'h0);
        if (wr) begin
            ref_mem[idx] = merge(ref_mem[idx], wdata, strb);
            chk("aw_cycles", aw_cyc, aw_dly + 1);
            chk("w_cycles", w_cyc, w_dly + 1);
        end else begin
            last_rd[d] = ref_mem[idx];
            chk("ar_cycles", ar_cyc, ar_dly + 1);
            chk("araddr_stable", araddr_bad, 0);
        end
        chk("rdata", prd(d), last_rd[d]);
        chk("other_rdata", prd(!d), last_rd[!d]);
        @(negedge clk); #1;
        chk("data_ok_pulse", 32'(dok(d)), 32'h0);
    endtask

    // AXI slave: wait states counted from the first cycle a valid/ready is seen.
    initial begin
        int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
        logic [3:0]  rd_idx, wr_idx, w_strb;
        logic [31:0] w_data, ar_first;
        ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        rd_idx = 4'h0; wr_idx = 4'h0; w_strb = 4'h0; w_data = 32'h0; ar_first = 32'h0;
        axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = 32'h0;
        axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (axi.arvalid) begin
                if (ar_cnt == 0) ar_first = axi.araddr;
                else if (axi.araddr !== ar_first) araddr_bad++;
                ar_cyc++;
                axi.arready = (ar_cnt >= ar_dly);
                if (axi.arready) begin
                    chk("araddr", axi.araddr, exp_addr);
                    rd_idx = axi.araddr[5:2];
                    ar_cnt = 0;
                end else ar_cnt++;
            end else begin axi.arready = 1'b0; ar_cnt = 0; end

            if (axi.rready) begin
                axi.rvalid = (r_cnt >= r_dly);
                if (axi.rvalid) begin axi.rdata = slave_mem[rd_idx]; r_cnt = 0; end
                else begin axi.rdata = $urandom; r_cnt++; end
            end else begin axi.rvalid = 1'b0; axi.rdata = $urandom; r_cnt = 0; end

            if (axi.awvalid) begin
                aw_cyc++;
                axi.awready = (aw_cnt >= aw_dly);
                if (axi.awready) begin
                    chk("awaddr", axi.awaddr, exp_addr);
                    wr_idx = axi.awaddr[5:2];
                    aw_cnt = 0;
                end else aw_cnt++;
            end else begin axi.awready = 1'b0; aw_cnt = 0; end

            if (axi.wvalid) begin
                w_cyc++;
                axi.wready = (w_cnt >= w_dly);
                if (axi.wready) begin
                    chk("wdata", axi.wdata, exp_wdata);
                    chk("wstrb", 32'(axi.wstrb), 32'(exp_wstrb));
                    w_data = axi.wdata; w_strb = axi.wstrb;
                    w_cnt = 0;
                end else w_cnt++;
            end else begin axi.wready = 1'b0; w_cnt = 0; end

            if (axi.bready) begin
                axi.bvalid = (b_cnt >= b_dly);
                if (axi.bvalid) begin
                    slave_mem[wr_idx] = merge(slave_mem[wr_idx], w_data, w_strb);
                    b_cnt = 0;
                end else b_cnt++;
            end else begin axi.bvalid = 1'b0; b_cnt = 0; end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, k;
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = init_word(i);
            slave_mem[i] = init_word(i);
        end
        last_rd[0] = 32'h0; last_rd[1] = 32'h0;
        ar_dly = 0; r_dly = 0; aw_dly = 0; w_dly = 0; b_dly = 0;
        ar_cyc = 0; aw_cyc = 0; w_cyc = 0; araddr_bad = 0;
        exp_addr = 32'h0; exp_wdata = 32'h0; exp_wstrb = 4'h0;

        // Requests held high during reset must not be acknowledged.
        reset = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 32'h1C00_0000, 32'h0, 4'h0);
        drive(1'b1, 1'b1, 1'b1, 32'h1C00_0004, 32'h0, 4'hF);
        repeat (3) @(negedge clk);
        #1;
        chk("rst_arvalid", 32'(axi.arvalid), 32'h0);
        chk("rst_rready", 32'(axi.rready), 32'h0);
        chk("rst_awvalid", 32'(axi.awvalid), 32'h0);
        chk("rst_wvalid", 32'(axi.wvalid), 32'h0);
        chk("rst_bready", 32'(axi.bready), 32'h0);
        chk("rst_inst_aok", 32'(inst_sram.addr_ok), 32'h0);
        chk("rst_data_aok", 32'(data_sram.addr_ok), 32'h0);
        chk("rst_inst_dok", 32'(inst_sram.data_ok), 32'h0);
        chk("rst_data_dok", 32'(data_sram.data_ok), 32'h0);
        chk("rst_inst_rdata", inst_sram.rdata, 32'h0);
        chk("rst_data_rdata", data_sram.rdata, 32'h0);
        chk("arlen", 32'(axi.arlen), 32'h0);
        chk("arsize", 32'(axi.arsize), 32'h2);
        chk("arburst", 32'(axi.arburst), 32'h1);
        chk("awsize", 32'(axi.awsize), 32'h2);
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

        // Instruction fetch with all readies high.
        do_txn(1'b0, 1'b0, 32'h1C00_0000, 32'h0, 4'h0);
        chk("inst_fetch_word", inst_sram.rdata, 32'h0280_0404);

        // Both ports request together: data first, inst right after data's DONE.
        exp_addr = 32'h1C00_000C; ar_cyc = 0; araddr_bad = 0;
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 32'h1C00_000C, 32'h0, 4'h0);
        drive(1'b0, 1'b1, 1'b0, 32'h1C00_0014, 32'h0, 4'h0);
        #1;
        chk("sim_data_aok", 32'(data_sram.addr_ok), 32'h1);
        chk("sim_inst_aok", 32'(inst_sram.addr_ok), 32'h0);
        wait_ok(1'b1, 1'b1, 40, n);
        chk("sim_data_latency", n, 3);
        chk("sim_aok_during", 32'(aok_seen), 32'h0);
        chk("sim_data_rdata", data_sram.rdata, ref_mem[3]);
        last_rd[1] = ref_mem[3];
        exp_addr = 32'h1C00_0014;
        @(negedge clk); #1;
        chk("sim_inst_aok_after", 32'(inst_sram.addr_ok), 32'h1);
        wait_ok(1'b0, 1'b1, 40, n);
        chk("sim_inst_latency", n, 3);
        chk("sim_inst_rdata", inst_sram.rdata, ref_mem[5]);
        last_rd[0] = ref_mem[5];

        // Partial-strobe data write, then a write whose address channel stalls.
        do_txn(1'b1, 1'b1, 32'h1C00_8000, 32'hDEAD_BEEF, 4'h3);
        aw_dly = 3;
        do_txn(1'b1, 1'b1, 32'h1C00_0024, 32'hA5C3_0F96, 4'hF);
        aw_dly = 0;

        // Slow read of the word just written.
        ar_dly = 5; r_dly = 2;
        do_txn(1'b1, 1'b0, 32'h1C00_0024, 32'h0, 4'h0);
        do_txn(1'b0, 1'b0, 32'h1C00_8000, 32'h0, 4'h0);
        ar_dly = 0; r_dly = 0;

        // Reset while waiting for read data abandons the transaction.
        r_dly = 10; exp_addr = 32'h1C00_001C; ar_cyc = 0; araddr_bad = 0;
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 32'h1C00_001C, 32'h0, 4'h0);
        #1;
        chk("rr_aok", 32'(data_sram.addr_ok), 32'h1);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk); #1;
        chk("rr_rready", 32'(axi.rready), 32'h1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rr_rready_in_reset", 32'(axi.rready), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rr_rready_after", 32'(axi.rready), 32'h0);
        chk("rr_arvalid_after", 32'(axi.arvalid), 32'h0);
        chk("rr_inst_rdata", inst_sram.rdata, 32'h0);
        chk("rr_data_rdata", data_sram.rdata, 32'h0);
        last_rd[0] = 32'h0; last_rd[1] = 32'h0;
        k = 0;
        for (int i = 0; i < 6; i++) begin
            if (data_sram.data_ok || inst_sram.data_ok) k++;
            @(negedge clk); #1;
        end
        chk("rr_no_data_ok", k, 0);
        r_dly = 0;
        do_txn(1'b1, 1'b0, 32'h1C00_001C, 32'h0, 4'h0);

        // Random mix of ports, directions, strobes and wait states.
        for (int t = 0; t < 40; t++) begin
            ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
            aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3);
            b_dly  = $urandom_range(0, 3);
            do_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   32'h1C00_0000 | ($urandom & 32'h0000_0FC0) | (32'($urandom_range(0, 15)) << 2),
                   $urandom, 4'($urandom_range(0, 15)));
        end

        // Read every word back to confirm the merged contents.
        ar_dly = 0; r_dly = 0; aw_dly = 0; w_dly = 0; b_dly = 0;
        for (int i = 0; i < 16; i++)
            do_txn(1'(i % 2), 1'b0, 32'h1C00_0000 | (32'(i) << 2), 32'h0, 4'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/sram_axi_bridge.md
# sram_axi_bridge

- Memory-side neighbour of the CPU core: sits between the core's instruction and data memory ports and the single system AXI port.
- Converts two request/addr_ok/data_ok "sram-like" ports into AXI-Lite-subset read and write transactions.
- One transaction is outstanding at a time; the data port has priority over the instruction port.
- The top-level wrapper ties constant AXI fields (len=0, burst=INCR, size=2, id=0, cache, prot, lock).

## Interface
Parameters:
- none

Ports (reset is synchronous, active-high, named `reset`; single clock `clk`):
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous active-high reset
- inst_sram_req / data_sram_req  in  1  request valid
- inst_sram_wr / data_sram_wr  in  1  1=write, 0=read
- inst_sram_wstrb / data_sram_wstrb  in  4  byte enables for writes
- inst_sram_addr / data_sram_addr  in  32  byte address
- inst_sram_wdata / data_sram_wdata  in  32  write data
- inst_sram_addr_ok / data_sram_addr_ok  out  1  request accepted this cycle
- inst_sram_data_ok / data_sram_data_ok  out  1  one-cycle completion pulse
- inst_sram_rdata / data_sram_rdata  out  32  read data, valid with data_ok
- araddr  out  32  read address
- arvalid  out  1  read address valid
- arready  in  1  read address ready
- rdata  in  32  read data
- rvalid  in  1  read data valid
- rready  out  1  read data ready
- awaddr  out  32  write address
- awvalid  out  1  write address valid
- awready  in  1  write address ready
- wdata  out  32  write data
- wstrb  out  4  write strobes
- wvalid  out  1  write data valid
- wready  in  1  write data ready
- bvalid  in  1  write response valid
- bready  out  1  write response ready

## Operation
- FSM states: IDLE, AR, R, AW_W, B, DONE.
- IDLE:
  - grant = data port if data_sram_req, else inst port.
  - addr_ok is driven combinationally high to the granted port only, when its req=1.
  - On accept, latch port id, wr, addr, wdata and wstrb.
  - Go to AR if read, AW_W if write.
- AR: arvalid=1, araddr=latched addr. On arready, go to R.
- R: rready=1. On rvalid, capture rdata into the granted port's rdata register, then go to DONE.
- AW_W:
  - awvalid and wvalid are raised together and held until each handshakes.
  - Two flags, aw_done and w_done, are set independently on handshake.
  - Leave for B in the cycle both are done, including when both handshake in the same cycle.
  - awvalid drops after aw_done; wvalid drops after w_done.
- B: bready=1. On bvalid, go to DONE.
- DONE: data_ok=1 for one cycle to the latched port only, then go to IDLE. addr_ok is 0 in DONE.
- Port rdata registers hold their value until the next read for that port. For writes, data_ok pulses and rdata is unchanged.
- rresp and bresp are ignored.
- A req that is not granted waits; it is never dropped. A steady data stream starves inst by design.

## Timing
- Reset: state=IDLE, aw_done=w_done=0, both rdata registers=0x00000000.
  - All AXI valid/ready outputs are 0, and addr_ok=data_ok=0 while reset=1.
  - Reset mid-transaction abandons the transaction with no data_ok.
- Read latency with arready and rvalid tied 1: accept in cycle 0; arvalid in cycle 1; rready and rvalid in cycle 2; data_ok in cycle 3.
- Write latency with all readies 1: accept in cycle 0; aw/w handshake in cycle 1; B in cycle 2; data_ok in cycle 3.
- Each extra ready or valid wait cycle adds one cycle.
- Back-to-back: the next addr_ok can occur in the cycle after DONE at the earliest, so 4 cycles per transaction minimum.
- AXI outputs are Moore (functions of state and flags only); no combinational path from AXI inputs to AXI outputs.

## Test plan
- Inst read 0x1C000000, arready=1, rvalid=1 with rdata=0x02800404 -> inst addr_ok in cycle 0, inst data_ok in cycle 3, inst_sram_rdata=0x02800404, data_data_ok stays 0.
- Simultaneous inst read and data read in the same cycle -> data_addr_ok=1 and inst_addr_ok=0. Data completes first; inst accepted in the cycle after data's DONE.
- Data write addr=0x1C008000, wdata=0xDEADBEEF, wstrb=0x3 -> awaddr=0x1C008000, wdata=0xDEADBEEF, wstrb=0x3 on AXI; one data_ok after bvalid.
- Write with awready delayed 3 cycles and wready=1 -> wvalid drops after its first cycle; awvalid is held 4 cycles; B is entered only after both handshakes.
- Read with arready low for 5 cycles then rvalid delayed 2 -> araddr stable throughout, a single data_ok, correct rdata.
- Assert reset while in R -> next cycle state=IDLE, rready=0, no data_ok. A fresh read then completes normally.
